// File: rtl/disp_scan8_if.sv
// disp_scan8_if: display content inputs and the per-digit decoder-facing outputs of the scanner.
interface disp_scan8_if;
    logic        load;
    logic [31:0] disp_data;
    logic [7:0]  point_in;
    logic [7:0]  blink_in;
    logic [7:0]  an;
    logic [3:0]  hex;
    logic        point;
    logic        le;
    logic        flash;
    logic        frame;
    modport master (output load, disp_data, point_in, blink_in,
                    input  an, hex, point, le, flash, frame);
    modport slave  (input  load, disp_data, point_in, blink_in,
                    output an, hex, point, le, flash, frame);
endinterface

// File: rtl/disp_scan8.sv
// disp_scan8: eight-digit multiplexed display scanner with frame-synchronous double-buffered content.
module disp_scan8 #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 25000000
) (
    input logic         clk,
    input logic         rst_n,
    disp_scan8_if.slave bus
);
    localparam int SW = $clog2(SCAN_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    logic [SW-1:0] scan_cnt;
    logic [BW-1:0] blink_cnt;
    logic [2:0]    idx;
    logic          flash_q, frame_q, pend_valid;
    logic [31:0]   data_a, data_p;
    logic [7:0]    point_a, point_p, blink_a, blink_p;
    logic          scan_wrap, blink_wrap, boundary;
    assign scan_wrap  = scan_cnt == SW'(SCAN_DIV - 1);
    assign blink_wrap = blink_cnt == BW'(BLINK_DIV - 1);
    assign boundary   = scan_wrap && idx == 3'd7;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt   <= '0;
            blink_cnt  <= '0;
            idx        <= '0;
            flash_q    <= 1'b0;
            frame_q    <= 1'b0;
            pend_valid <= 1'b0;
            data_a     <= '0;
            point_a    <= '0;
            blink_a    <= '0;
            data_p     <= '0;
            point_p    <= '0;
            blink_p    <= '0;
        end else begin
            scan_cnt  <= scan_wrap ? '0 : scan_cnt + 1'b1;
            blink_cnt <= blink_wrap ? '0 : blink_cnt + 1'b1;
            if (scan_wrap) idx <= idx + 3'd1;
            if (blink_wrap) flash_q <= ~flash_q;
            frame_q <= boundary;
            // a load on the boundary edge bypasses pending and commits live content directly
            if (boundary) begin
                if (bus.load) begin
                    data_a  <= bus.disp_data;
                    point_a <= bus.point_in;
                    blink_a <= bus.blink_in;
                end else if (pend_valid) begin
                    data_a  <= data_p;
                    point_a <= point_p;
                    blink_a <= blink_p;
                end
                pend_valid <= 1'b0;
            end else if (bus.load) begin
                data_p     <= bus.disp_data;
                point_p    <= bus.point_in;
                blink_p    <= bus.blink_in;
                pend_valid <= 1'b1;
            end
        end
    end
    assign bus.an    = ~(8'b1 << idx);
    assign bus.hex   = data_a[{idx, 2'b00} +: 4];
    assign bus.point = point_a[idx];
    assign bus.le    = blink_a[idx];
    assign bus.flash = flash_q;
    assign bus.frame = frame_q;
endmodule

// File: doc/disp_scan8.md
# disp_scan8

Eight-digit time-multiplexed display scanner driving the hex-to-segment decoder stage. It holds a 32-bit display word plus per-digit decimal-point and blink-enable masks, and steps one digit at a time. Each step drives one active-low anode select and presents that digit's nibble, point and blink enable, along with a free-running blink phase, to the decoder's Hex/point/LE/flash inputs. New display content is double-buffered and committed only at a frame boundary, so the panel never shows a mix of old and new digits.

## Interface
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal range ≥2.
- BLINK_DIV, 25000000: clock cycles per blink-phase half-period; legal range ≥2.

- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  one-cycle strobe; samples disp_data, point_in and blink_in.
- disp_data  in  32  eight hex digits; digit k is disp_data[4k+3:4k].
- point_in  in  8  bit k is the decimal-point request for digit k.
- blink_in  in  8  bit k=1 makes digit k blink.
- an  out  8  anode select, active-low, exactly one bit low after reset.
- hex  out  4  nibble of the selected digit.
- point  out  1  point bit of the selected digit.
- le  out  1  blink enable of the selected digit.
- flash  out  1  blink phase. 1 = off phase; the decoder blanks when le & flash.
- frame  out  1  one-cycle pulse on the cycle after each commit boundary.

## Operation
- Registers:
  - scan_cnt: $clog2(SCAN_DIV) bits.
  - idx: 3 bits.
  - blink_cnt: $clog2(BLINK_DIV) bits.
  - flash: register.
  - active buffer: 48 bits = data 32, point 8, blink 8.
  - pending buffer: 48 bits, plus a pend_valid flag.
- Scan counter:
  - scan_cnt increments every cycle.
  - At SCAN_DIV-1 it wraps to 0 and idx increments modulo 8 (7→0).
- Boundary: the cycle where idx==7 and scan_cnt==SCAN_DIV-1. On that edge:
  - idx goes to 0.
  - The active buffer is updated by priority:
    - load=1: active gets the live inputs.
    - else pend_valid=1: active gets the pending buffer.
    - else: active unchanged.
  - pend_valid clears.
  - frame is set to 1 for one cycle.
- load away from the boundary:
  - Pending gets the live inputs and pend_valid is set.
  - Multiple loads within one frame: the last one wins.
- Blink:
  - blink_cnt increments every cycle.
  - At BLINK_DIV-1 it wraps to 0 and flash toggles.
  - Blink is independent of scan and load.
- Output decode (combinational from registered idx and active buffer, no combinational input-to-output path):
  - an = ~(8'b1 << idx).
  - hex = active.data[4·idx+3 : 4·idx].
  - point = active.point[idx].
  - le = active.blink[idx].
- Reset (async, rst_n=0):
  - scan_cnt=0, idx=0, blink_cnt=0, flash=0, frame=0.
  - active=0, pending=0, pend_valid=0.
  - Resulting outputs: an=8'hFE, hex=0, point=0, le=0, flash=0, frame=0.
- Reset asserted mid-frame discards any pending content. After release, scanning restarts at digit 0 with scan_cnt=0.

## Timing
- Each digit is selected for exactly SCAN_DIV cycles; a full frame is 8·SCAN_DIV cycles.
- an, hex, point and le change on the same edge as idx. They are always mutually consistent and never show a mixed digit.
- Commit latency from a load strobe:
  - load on a boundary cycle: content is visible on the next cycle.
  - otherwise: content is visible on the cycle after the next boundary, i.e. at most 8·SCAN_DIV cycles later.
- flash period is 2·BLINK_DIV cycles, 50% duty. The first toggle is BLINK_DIV cycles after reset release.
- frame goes high the cycle after the boundary edge, coincident with idx==0 and scan_cnt==0. It is low otherwise.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_DIV=8.
- Reset values: hold rst_n=0, then release. Required:
  - outputs exactly as listed in the reset paragraph;
  - an sequence FE,FD,FB,F7,EF,DF,BF,7F, each held 4 cycles, then back to FE;
  - frame pulses every 32 cycles.
- Load mid-frame: load disp_data=32'h76543210, point_in=8'h81 at idx=2. Required:
  - hex stays 0 until the boundary;
  - then digits 0..7 show 0..7;
  - point=1 only at idx 0 and idx 7.
- Load on boundary: load at the boundary cycle with data 32'hDEADBEEF and a different value pending. Required: the live data wins and hex=F at the next cycle, idx=0.
- Multiple loads per frame: loads of 32'h11111111 and then 32'h22222222 in one frame. Required: the next frame shows all 2s and never shows 1s.
- Blink: blink_in=8'h01. Required:
  - flash toggles every 8 cycles;
  - le=1 only while idx==0.
- Async reset mid-operation: rst_n low mid-frame with pend_valid=1. Required:
  - outputs go to reset values immediately, without waiting for a clock edge;
  - after release and one full frame, hex shows 0 for all digits, because the pending content was discarded.
